// File: rtl/mac_dot_accumulator.sv
// Dot-product accumulator: registers 4x4 array-multiplier products and sums N_TERMS of them.
// Optional build macro SAT_ACCUM_EN: saturating accumulator with a sticky out_ovf flag.

module arraymultiplier (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] m
);
    logic [3:0][3:0] pp;

    always_comb begin
        m = '0;
        for (int i = 0; i < 4; i++) begin
            pp[i] = a & {4{b[i]}};
            m = m + (8'(pp[i]) << i);
        end
    end
endmodule

module mac_dot_accumulator #(
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 12,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_a,
    input  logic [3:0]       in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum
`ifdef SAT_ACCUM_EN
    ,
    output logic             out_ovf
`endif
);
    // state | meaning
    // RUN   | accepting operand pairs until N_TERMS have been taken
    // DRAIN | inputs closed, waiting for the final product to be added
    // DONE  | result presented on out_sum, waiting for out_ready
    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    state_t           state, state_nxt;
    logic             rst_done;
    logic [7:0]       m;
    logic [7:0]       p_q;
    logic             p_vld;
    logic [ACC_W-1:0] acc, acc_nxt;
    logic [CNT_W-1:0] acc_cnt, acc_in_cnt;
    logic             ovf, sat_hit;
    logic             accept, handshake;

    arraymultiplier u_mult (
        .a (in_a),
        .b (in_b),
        .m (m)
    );

    // rst_done keeps in_ready low while reset is held, without using rst_n as data
    assign in_ready  = rst_done && (state == RUN) && (acc_in_cnt < CNT_W'(N_TERMS));
    assign accept    = in_valid && in_ready && !clr;
    assign handshake = (state == DONE) && out_ready;
    assign out_valid = (state == DONE);
    assign out_sum   = acc;

`ifdef SAT_ACCUM_EN
    logic [ACC_W:0] sum_full;
    always_comb begin
        sum_full = {1'b0, acc} + (ACC_W+1)'(p_q);
        sat_hit  = sum_full[ACC_W];
        acc_nxt  = sat_hit ? '1 : sum_full[ACC_W-1:0];
    end
    assign out_ovf = ovf;
`else
    always_comb begin
        acc_nxt = acc + ACC_W'(p_q);
        sat_hit = 1'b0;
    end
`endif

    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = RUN;
        end else begin
            case (state)
                RUN:   if (accept && (acc_in_cnt == CNT_W'(N_TERMS - 1))) state_nxt = DRAIN;
                DRAIN: if (p_vld && (acc_cnt == CNT_W'(N_TERMS - 1)))     state_nxt = DONE;
                DONE:  if (out_ready)                                      state_nxt = RUN;
                default: state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            rst_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            rst_done <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q        <= '0;
            p_vld      <= 1'b0;
            acc        <= '0;
            acc_cnt    <= '0;
            acc_in_cnt <= '0;
            ovf        <= 1'b0;
        end else if (clr) begin
            p_q        <= '0;
            p_vld      <= 1'b0;
            acc        <= '0;
            acc_cnt    <= '0;
            acc_in_cnt <= '0;
            ovf        <= 1'b0;
        end else begin
            p_vld <= accept;
            if (accept) begin
                p_q        <= m;
                acc_in_cnt <= acc_in_cnt + CNT_W'(1);
            end
            // p_vld is never set in DONE, so the handshake clear cannot race an add
            if (handshake) begin
                acc        <= '0;
                acc_cnt    <= '0;
                acc_in_cnt <= '0;
                ovf        <= 1'b0;
            end else if (p_vld) begin
                acc     <= acc_nxt;
                acc_cnt <= acc_cnt + CNT_W'(1);
                ovf     <= ovf | sat_hit;
            end
        end
    end
endmodule

// File: tb/tb_mac_dot_accumulator.sv
// Directed bench for mac_dot_accumulator: three parameter sets, table vectors plus
// hand-written clr, async-reset and latency sequences.

module tb_mac_dot_accumulator;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr = 1'b0;
    logic [2:0] in_valid_v = '0;
    logic [2:0] in_ready_v;
    logic [2:0][3:0] in_a_v = '0;
    logic [2:0][3:0] in_b_v = '0;
    logic [2:0] out_valid_v;
    logic [2:0] out_ready_v = '0;
    logic [2:0] out_ovf_v;
    logic [11:0] sum0;
    logic [9:0]  sum1;
    logic [11:0] sum2;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    mac_dot_accumulator #(.N_TERMS(4), .ACC_W(12), .CNT_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .in_a(in_a_v[0]), .in_b(in_b_v[0]),
        .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]), .out_sum(sum0)
`ifdef SAT_ACCUM_EN
        , .out_ovf(out_ovf_v[0])
`endif
    );

    mac_dot_accumulator #(.N_TERMS(8), .ACC_W(10), .CNT_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .in_a(in_a_v[1]), .in_b(in_b_v[1]),
        .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]), .out_sum(sum1)
`ifdef SAT_ACCUM_EN
        , .out_ovf(out_ovf_v[1])
`endif
    );

    mac_dot_accumulator #(.N_TERMS(1), .ACC_W(12), .CNT_W(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .in_a(in_a_v[2]), .in_b(in_b_v[2]),
        .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]), .out_sum(sum2)
`ifdef SAT_ACCUM_EN
        , .out_ovf(out_ovf_v[2])
`endif
    );

`ifndef SAT_ACCUM_EN
    assign out_ovf_v = '0;
`endif

    typedef struct {
        string           name;
        int              sel;
        int              n;
        logic [7:0][3:0] a;
        logic [7:0][3:0] b;
        logic [7:0][1:0] gap;
        int              exp_sum;
        logic            exp_ovf;
    } vec_t;

    vec_t vecs[6];

    function automatic int get_sum(int s);
        if (s == 0) return int'(sum0);
        if (s == 1) return int'(sum1);
        return int'(sum2);
    endfunction

    task automatic chk(string name, int act, int exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(int s, logic [3:0] a, logic [3:0] b);
        in_a_v[s] = a;
        in_b_v[s] = b;
        in_valid_v[s] = 1'b1;
        for (int n = 0; n < 40 && !in_ready_v[s]; n++) step();
        chk("send in_ready", int'(in_ready_v[s]), 1);
        step();
        in_valid_v[s] = 1'b0;
    endtask

    task automatic run_vec(vec_t v);
        int s;
        s = v.sel;
        for (int k = 0; k < v.n; k++) begin
            repeat (int'(v.gap[k])) step();
            send(s, v.a[k], v.b[k]);
        end
        chk({v.name, " drain in_ready"}, int'(in_ready_v[s]), 0);
        chk({v.name, " drain out_valid"}, int'(out_valid_v[s]), 0);
        step();
        chk({v.name, " out_valid"}, int'(out_valid_v[s]), 1);
        chk({v.name, " out_sum"}, get_sum(s), v.exp_sum);
        chk({v.name, " out_ovf"}, int'(out_ovf_v[s]), int'(v.exp_ovf));
        for (int h = 0; h < 5; h++) begin
            step();
            chk({v.name, " hold out_valid"}, int'(out_valid_v[s]), 1);
            chk({v.name, " hold out_sum"}, get_sum(s), v.exp_sum);
            chk({v.name, " hold in_ready"}, int'(in_ready_v[s]), 0);
        end
        out_ready_v[s] = 1'b1;
        step();
        out_ready_v[s] = 1'b0;
        chk({v.name, " post out_valid"}, int'(out_valid_v[s]), 0);
        chk({v.name, " post in_ready"}, int'(in_ready_v[s]), 1);
        chk({v.name, " post acc"}, get_sum(s), 0);
        chk({v.name, " post out_ovf"}, int'(out_ovf_v[s]), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;

        vecs[0] = '{name: "sq15x4", sel: 0, n: 4, a: {8{4'd15}}, b: {8{4'd15}},
                    gap: '0, exp_sum: 900, exp_ovf: 1'b0};
        vecs[1] = '{name: "gaps", sel: 0, n: 4,
                    a: {4'd0, 4'd0, 4'd0, 4'd0, 4'd7, 4'd5, 4'd3, 4'd1},
                    b: {4'd0, 4'd0, 4'd0, 4'd0, 4'd8, 4'd6, 4'd4, 4'd2},
                    gap: {2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0},
                    exp_sum: 100, exp_ovf: 1'b0};
`ifdef SAT_ACCUM_EN
        vecs[2] = '{name: "n8wide", sel: 1, n: 8, a: {8{4'd15}}, b: {8{4'd15}},
                    gap: '0, exp_sum: 1023, exp_ovf: 1'b1};
`else
        vecs[2] = '{name: "n8wrap", sel: 1, n: 8, a: {8{4'd15}}, b: {8{4'd15}},
                    gap: '0, exp_sum: 776, exp_ovf: 1'b0};
`endif
        vecs[3] = '{name: "n1zero", sel: 2, n: 1, a: {8{4'd0}}, b: {8{4'd9}},
                    gap: '0, exp_sum: 0, exp_ovf: 1'b0};
        vecs[4] = '{name: "n1fifteen", sel: 2, n: 1, a: {8{4'd15}}, b: {8{4'd1}},
                    gap: '0, exp_sum: 15, exp_ovf: 1'b0};
        vecs[5] = '{name: "mixed", sel: 0, n: 4,
                    a: {4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd12, 4'd9, 4'd4},
                    b: {4'd0, 4'd0, 4'd0, 4'd0, 4'd15, 4'd10, 4'd11, 4'd13},
                    gap: {2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd2},
                    exp_sum: 271, exp_ovf: 1'b0};

        // reset state
        #12;
        chk("reset in_ready", int'(in_ready_v[0]), 0);
        chk("reset out_valid", int'(out_valid_v[0]), 0);
        chk("reset out_sum", get_sum(0), 0);
        chk("reset out_ovf", int'(out_ovf_v[0]), 0);
        rst_n = 1'b1;
        step();
        chk("release in_ready", int'(in_ready_v[0]), 1);
        chk("release in_ready n1", int'(in_ready_v[2]), 1);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // clr after two accepts with a product still in flight
        send(0, 4'd9, 4'd9);
        send(0, 4'd9, 4'd9);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr out_sum", get_sum(0), 0);
        chk("clr in_ready", int'(in_ready_v[0]), 1);
        chk("clr out_valid", int'(out_valid_v[0]), 0);
        step();
        chk("clr discard in-flight", get_sum(0), 0);
        v = '{name: "afterclr", sel: 0, n: 4, a: {8{4'd2}}, b: {8{4'd3}},
              gap: '0, exp_sum: 24, exp_ovf: 1'b0};
        run_vec(v);

        // async reset while draining
        send(0, 4'd15, 4'd15);
        send(0, 4'd15, 4'd15);
        send(0, 4'd15, 4'd15);
        send(0, 4'd15, 4'd15);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst out_valid", int'(out_valid_v[0]), 0);
        chk("async rst in_ready", int'(in_ready_v[0]), 0);
        chk("async rst out_sum", get_sum(0), 0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        step();
        chk("rst release in_ready", int'(in_ready_v[0]), 1);
        chk("rst release out_valid", int'(out_valid_v[0]), 0);
        v = '{name: "afterrst", sel: 0, n: 4, a: {8{4'd1}}, b: {8{4'd1}},
              gap: '0, exp_sum: 4, exp_ovf: 1'b0};
        run_vec(v);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
